ifc_ok_event_queue: RTL and testbench

//  Downstream consumer of the ifc interface's `ok` field: samples ifc.ok every clk.

---
 rtl/ifc_ok_event_pkg.sv | 18 +
 rtl/ifc_ok_event_queue_if.sv | 7 +
 rtl/ifc_ok_event_fifo.sv | 52 +++++
 rtl/ifc_ok_event_queue.sv | 84 ++++++++
 tb/tb_ifc_ok_event_queue.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ifc_ok_event_pkg.sv
// Shared types and default sizes for the ifc.ok change-event queue.
// The stamp field exists only when IFC_OK_EVENT_TS_EN is defined.
package ifc_ok_event_pkg;

  localparam int EVT_DEPTH  = 4;
  localparam int EVT_SEQ_W  = 8;
  localparam int EVT_DROP_W = 8;
  localparam int EVT_TS_W   = 16;

  typedef struct packed {
    logic [31:0]          value;
    logic [EVT_SEQ_W-1:0] seq;
`ifdef IFC_OK_EVENT_TS_EN
    logic [EVT_TS_W-1:0]  stamp;
`endif
  } ifc_ok_event_t;

endpackage

// File: rtl/ifc_ok_event_queue_if.sv
// The ifc interface carrying the 32-bit ok field between its driver and its consumers.
interface ifc;
  logic [31:0] ok;

  modport out_modport (output ok);
  modport in_modport  (input ok);
endinterface

// File: rtl/ifc_ok_event_fifo.sv
// Synchronous FIFO of ifc_ok_event_t; the head reads as zero while empty.
module ifc_ok_event_fifo
  import ifc_ok_event_pkg::*;
#(
  parameter int DEPTH = EVT_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  ifc_ok_event_t          din,
  input  logic                   pop,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output ifc_ok_event_t          head
);
  localparam int AW = $clog2(DEPTH);

  ifc_ok_event_t mem [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign count   = cnt_q;
  assign head    = empty ? '0 : mem[rd_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q] <= din;
  end

endmodule

// File: rtl/ifc_ok_event_queue.sv
// Turns every change of ifc.ok into a sequenced event queued for a valid/ready consumer.
// Define IFC_OK_EVENT_TS_EN to add a free-running cycle stamp to each event (o_stamp).
module ifc_ok_event_queue
  import ifc_ok_event_pkg::*;
#(
  parameter int DEPTH  = EVT_DEPTH,
  parameter int SEQ_W  = EVT_SEQ_W,
  parameter int DROP_W = EVT_DROP_W,
  parameter int TS_W   = EVT_TS_W
) (
  input  logic                   clk,
  input  logic                   rst,
  ifc.in_modport                 isrc,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [31:0]            o_value,
  output logic [SEQ_W-1:0]       o_seq,
  output logic [$clog2(DEPTH):0] o_count,
  output logic [DROP_W-1:0]      o_drop_cnt
`ifdef IFC_OK_EVENT_TS_EN
  ,
  output logic [TS_W-1:0]        o_stamp
`endif
);

  logic [31:0]       prev_q;
  logic              base_vld_q;
  logic [SEQ_W-1:0]  seq_q;
  logic [DROP_W-1:0] drop_q;
  logic              change, pop, full, empty;
  ifc_ok_event_t     push_evt, head;

  // Four-state compare so X/Z bits on ok also register as a change.
  assign change = base_vld_q && (isrc.ok !== prev_q);
  assign pop    = o_valid && i_ready;

  assign push_evt.value = isrc.ok;
  assign push_evt.seq   = seq_q;

`ifdef IFC_OK_EVENT_TS_EN
  logic [TS_W-1:0] ts_q;

  assign push_evt.stamp = ts_q;
  assign o_stamp        = head.stamp;

  always_ff @(posedge clk) begin
    if (rst) ts_q <= '0;
    else     ts_q <= ts_q + 1'b1;
  end
`endif

  ifc_ok_event_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (change),
    .din   (push_evt),
    .pop   (pop),
    .full  (full),
    .empty (empty),
    .count (o_count),
    .head  (head)
  );

  assign o_valid    = !empty;
  assign o_value    = head.value;
  assign o_seq      = head.seq;
  assign o_drop_cnt = drop_q;

  // The sequence number advances on every change, dropped or not, so losses show as gaps.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q     <= '0;
      base_vld_q <= 1'b0;
      seq_q      <= '0;
      drop_q     <= '0;
    end else begin
      prev_q     <= isrc.ok;
      base_vld_q <= 1'b1;
      if (change) seq_q <= seq_q + 1'b1;
      if (change && full && !pop && (drop_q != '1)) drop_q <= drop_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_ifc_ok_event_queue.sv
// Randomized and directed bench for ifc_ok_event_queue against a queue-based event model.
// Covers the stamp output as well when IFC_OK_EVENT_TS_EN is defined.
module tb_ifc_ok_event_queue;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_value;
  logic [7:0]  o_seq;
  logic [2:0]  o_count;
  logic [7:0]  o_drop_cnt;
`ifdef IFC_OK_EVENT_TS_EN
  logic [15:0] o_stamp;
`endif

  ifc isrc_if ();

  ifc_ok_event_queue dut (
    .clk        (clk),
    .rst        (rst),
    .isrc       (isrc_if.in_modport),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_value    (o_value),
    .o_seq      (o_seq),
    .o_count    (o_count),
    .o_drop_cnt (o_drop_cnt)
`ifdef IFC_OK_EVENT_TS_EN
    ,
    .o_stamp    (o_stamp)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] value;
    int          seq;
    int          stamp;
  } mev_t;

  mev_t        mq[$];
  logic [31:0] m_prev;
  bit          m_base;
  int          m_seq;
  int          m_drop;
  int          m_ts;

  // Reference: an event list with a capacity; the head may leave before a new one arrives.
  function automatic void model_edge(input logic [31:0] ok_v, input bit rdy, input bit r);
    bit pop_now;
    bit chg;
    if (r) begin
      mq.delete();
      m_prev = '0;
      m_base = 0;
      m_seq  = 0;
      m_drop = 0;
      m_ts   = 0;
      return;
    end
    pop_now = (mq.size() > 0) && rdy;
    chg     = m_base && (ok_v !== m_prev);
    if (pop_now) void'(mq.pop_front());
    if (chg) begin
      if (mq.size() < DEPTH) mq.push_back('{value: ok_v, seq: m_seq, stamp: m_ts});
      else if (m_drop < 255) m_drop++;
      m_seq = (m_seq + 1) % 256;
    end
    m_prev = ok_v;
    m_base = 1;
    m_ts   = (m_ts + 1) % 65536;
  endfunction

  task automatic step(input logic [31:0] ok_v, input bit rdy, input bit r);
    isrc_if.ok = ok_v;
    i_ready    = rdy;
    rst        = r;
    @(posedge clk);
    model_edge(ok_v, rdy, r);
    @(negedge clk);
  endtask

  task automatic test_reset();
    step(5, 1, 1);
    step(5, 1, 1);
    checks++;
    if (o_valid !== 1'b0 || o_count !== 3'd0 || o_drop_cnt !== 8'd0 || o_value !== 32'd0 || o_seq !== 8'd0) begin
      errors++;
      $display("[TB] FAIL reset_state: valid=%b count=%0d drop=%0d value=%0d seq=%0d, required all zero",
               o_valid, o_count, o_drop_cnt, o_value, o_seq);
    end
    for (int i = 0; i < 10; i++) begin
      step(5, 1, 0);
      checks++;
      if (o_valid !== 1'b0 || o_count !== 3'd0) begin
        errors++;
        $display("[TB] FAIL baseline_no_event cyc%0d: valid=%b count=%0d, required 0/0", i, o_valid, o_count);
      end
    end
  endtask

  task automatic test_single_change();
    step(9, 1, 0);
    checks++;
    if (o_valid !== 1'b1 || o_value !== 32'd9 || o_seq !== 8'd0 || o_count !== 3'd1) begin
      errors++;
      $display("[TB] FAIL single_change: valid=%b value=%0d seq=%0d count=%0d, required 1/9/0/1",
               o_valid, o_value, o_seq, o_count);
    end
    step(9, 1, 0);
    checks++;
    if (o_valid !== 1'b0 || o_count !== 3'd0) begin
      errors++;
      $display("[TB] FAIL single_pop: valid=%b count=%0d, required 0/0", o_valid, o_count);
    end
  endtask

  task automatic test_overflow();
    step(0, 0, 1);
    step(0, 0, 0);
    for (int v = 1; v <= 6; v++) step(v, 0, 0);
    checks++;
    if (o_count !== 3'd4 || o_drop_cnt !== 8'd2) begin
      errors++;
      $display("[TB] FAIL overflow: count=%0d drop=%0d, required 4/2", o_count, o_drop_cnt);
    end
    for (int i = 1; i <= 4; i++) begin
      checks++;
      if (o_valid !== 1'b1 || o_value !== 32'(i) || o_seq !== 8'(i - 1)) begin
        errors++;
        $display("[TB] FAIL overflow_drain%0d: valid=%b value=%0d seq=%0d, required 1/%0d/%0d",
                 i, o_valid, o_value, o_seq, i, i - 1);
      end
      step(6, 1, 0);
    end
    step(7, 1, 0);
    checks++;
    if (o_value !== 32'd7 || o_seq !== 8'd6 || o_drop_cnt !== 8'd2) begin
      errors++;
      $display("[TB] FAIL seq_gap: value=%0d seq=%0d drop=%0d, required 7/6/2", o_value, o_seq, o_drop_cnt);
    end
  endtask

  task automatic test_full_push_pop();
    step(10, 0, 1);
    step(10, 0, 0);
    for (int v = 11; v <= 14; v++) step(v, 0, 0);
    step(15, 1, 0);
    checks++;
    if (o_count !== 3'd4 || o_drop_cnt !== 8'd0 || o_value !== 32'd12) begin
      errors++;
      $display("[TB] FAIL full_push_pop: count=%0d drop=%0d head=%0d, required 4/0/12", o_count, o_drop_cnt, o_value);
    end
    for (int v = 12; v <= 15; v++) begin
      checks++;
      if (o_value !== 32'(v)) begin
        errors++;
        $display("[TB] FAIL full_push_pop_order: head=%0d, required %0d", o_value, v);
      end
      step(15, 1, 0);
    end
  endtask

  task automatic test_reset_mid();
    step(20, 0, 1);
    step(20, 0, 0);
    for (int v = 21; v <= 23; v++) step(v, 0, 0);
    step(23, 0, 1);
    checks++;
    if (o_count !== 3'd0 || o_drop_cnt !== 8'd0 || o_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid: count=%0d drop=%0d valid=%b, required 0/0/0", o_count, o_drop_cnt, o_valid);
    end
    for (int i = 0; i < 4; i++) begin
      step(23, 1, 0);
      checks++;
      if (o_valid !== 1'b0 || o_count !== 3'd0) begin
        errors++;
        $display("[TB] FAIL reset_mid_spurious cyc%0d: valid=%b count=%0d, required 0/0", i, o_valid, o_count);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] e_value;
    int          e_seq;
    step(0, 0, 1);
    for (int i = 0; i < 400; i++) begin
      step(32'($urandom_range(0, 3)), bit'($urandom_range(0, 2) == 0), bit'($urandom_range(0, 99) == 0));
      e_value = (mq.size() > 0) ? mq[0].value : 32'd0;
      e_seq   = (mq.size() > 0) ? mq[0].seq : 0;
      checks++;
      if (o_valid !== (mq.size() > 0) || o_count !== 3'(mq.size()) || o_drop_cnt !== 8'(m_drop) ||
          o_value !== e_value || o_seq !== 8'(e_seq)) begin
        errors++;
        $display("[TB] FAIL random cyc%0d: valid=%b count=%0d drop=%0d value=%0d seq=%0d, required %0b/%0d/%0d/%0d/%0d",
                 i, o_valid, o_count, o_drop_cnt, o_value, o_seq, mq.size() > 0, mq.size(), m_drop, e_value, e_seq);
      end
`ifdef IFC_OK_EVENT_TS_EN
      checks++;
      if (o_stamp !== 16'((mq.size() > 0) ? mq[0].stamp : 0)) begin
        errors++;
        $display("[TB] FAIL random_stamp cyc%0d: stamp=%0d, required %0d",
                 i, o_stamp, (mq.size() > 0) ? mq[0].stamp : 0);
      end
`endif
    end
  endtask

  task automatic test_seq_wrap();
    step(0, 1, 1);
    step(0, 1, 0);
    for (int k = 0; k < 300; k++) begin
      step(32'(k + 1), 1, 0);
      checks++;
      if (o_seq !== 8'(k % 256) || o_count !== 3'd1 || o_value !== 32'(k + 1)) begin
        errors++;
        $display("[TB] FAIL seq_wrap k%0d: seq=%0d count=%0d value=%0d, required %0d/1/%0d",
                 k, o_seq, o_count, o_value, k % 256, k + 1);
      end
    end
  endtask

`ifdef IFC_OK_EVENT_TS_EN
  task automatic test_stamp();
    step(3, 0, 1);
    for (int e = 0; e < 7; e++) step(3, 0, 0);
    step(4, 0, 0);
    checks++;
    if (o_valid !== 1'b1 || o_stamp !== 16'd7) begin
      errors++;
      $display("[TB] FAIL stamp: valid=%b stamp=%0d, required 1/7", o_valid, o_stamp);
    end
  endtask
`endif

  initial begin
    rst        = 1'b1;
    i_ready    = 1'b0;
    isrc_if.ok = '0;
    @(negedge clk);
    test_reset();
    test_single_change();
    test_overflow();
    test_full_push_pop();
    test_reset_mid();
    test_random();
    test_seq_wrap();
`ifdef IFC_OK_EVENT_TS_EN
    test_stamp();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
